// File: rtl/bus_pkg.sv
// Shared definitions for the SHA/AES transaction bus arbiter: owner encodings,
// opcode field placement and per-transaction byte count.
package bus_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_AES  = 2'b01,
        MODE_SHA  = 2'b10
    } mode_e;

    localparam int unsigned OPCODE_W = 8;

    // Opcode occupies the top byte, directly above the address.
    function automatic int unsigned opcode_msb(input int unsigned addrw);
        return addrw + OPCODE_W - 1;
    endfunction

    function automatic int unsigned opcode_lsb(input int unsigned addrw);
        return addrw;
    endfunction

    function automatic int unsigned nbytes(input int unsigned addrw);
        return addrw / 8 + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting SHA or AES the shared 8-bit bus, then streaming
// the winner's {opcode, address} word MSB-byte-first under valid/ready.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDRW = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sha_req,
    input  logic               aes_req,
    input  logic [ADDRW+7:0]   sha_data_in,
    input  logic [ADDRW+7:0]   aes_data_in,
    input  logic               bus_ready,
    output logic [7:0]         data_out,
    output logic               valid_out,
    output logic               aes_grant,
    output logic               sha_grant,
    output logic [1:0]         curr_mode_top,
    output logic [1:0]         counter_top
);

    localparam int unsigned WORD_W   = ADDRW + OPCODE_W;
    localparam int unsigned OPC_MSB  = opcode_msb(ADDRW);
    localparam int unsigned NBYTES   = nbytes(ADDRW);
    localparam logic [1:0]  LAST_IDX = 2'(NBYTES - 1);

    mode_e              mode_q;
    logic [1:0]         counter_q;
    logic [WORD_W-1:0]  word_q;
    logic               last_sha_q;
    logic               pick_aes;
    logic               accept;

    // AES wins when alone, or on contention if SHA was served last.
    assign pick_aes = aes_req && (!sha_req || last_sha_q);
    assign accept   = valid_out && bus_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_IDLE;
            counter_q  <= 2'd0;
            word_q     <= '0;
            last_sha_q <= 1'b1;
            aes_grant  <= 1'b0;
            sha_grant  <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= 8'h00;
        end else begin
            case (mode_q)
                MODE_IDLE: begin
                    if (aes_req || sha_req) begin
                        // word_q holds the bytes still to be presented, left-aligned.
                        if (pick_aes) begin
                            mode_q    <= MODE_AES;
                            aes_grant <= 1'b1;
                            data_out  <= aes_data_in[OPC_MSB -: 8];
                            word_q    <= aes_data_in << 8;
                        end else begin
                            mode_q    <= MODE_SHA;
                            sha_grant <= 1'b1;
                            data_out  <= sha_data_in[OPC_MSB -: 8];
                            word_q    <= sha_data_in << 8;
                        end
                        valid_out <= 1'b1;
                        counter_q <= 2'd0;
                    end
                end
                MODE_AES, MODE_SHA: begin
                    if (accept) begin
                        if (counter_q == LAST_IDX) begin
                            last_sha_q <= (mode_q == MODE_SHA);
                            mode_q     <= MODE_IDLE;
                            counter_q  <= 2'd0;
                            aes_grant  <= 1'b0;
                            sha_grant  <= 1'b0;
                            valid_out  <= 1'b0;
                            data_out   <= 8'h00;
                        end else begin
                            counter_q <= counter_q + 2'd1;
                            data_out  <= word_q[WORD_W-1 -: 8];
                            word_q    <= word_q << 8;
                        end
                    end
                end
                default: begin
                    mode_q    <= MODE_IDLE;
                    counter_q <= 2'd0;
                    aes_grant <= 1'b0;
                    sha_grant <= 1'b0;
                    valid_out <= 1'b0;
                    data_out  <= 8'h00;
                end
            endcase
        end
    end

    assign curr_mode_top = mode_q;
    assign counter_top   = counter_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single requesters, stalls, round-robin,
// mid-transfer request drop and mid-transfer reset.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sha_req, aes_req;
    logic [31:0] sha_data_in, aes_data_in;
    logic        bus_ready;
    logic [7:0]  data_out;
    logic        valid_out, aes_grant, sha_grant;
    logic [1:0]  curr_mode_top, counter_top;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDRW(24)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sha_req       (sha_req),
        .aes_req       (aes_req),
        .sha_data_in   (sha_data_in),
        .aes_data_in   (aes_data_in),
        .bus_ready     (bus_ready),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .aes_grant     (aes_grant),
        .sha_grant     (sha_grant),
        .curr_mode_top (curr_mode_top),
        .counter_top   (counter_top)
    );

    // {aes_grant, sha_grant, valid_out, mode, counter, data}
    logic [14:0] obs;
    assign obs = {aes_grant, sha_grant, valid_out, curr_mode_top, counter_top, data_out};

    function automatic logic [14:0] ev(input logic ag, input logic sg, input logic v,
                                       input logic [1:0] m, input logic [1:0] c,
                                       input logic [7:0] d);
        return {ag, sg, v, m, c, d};
    endfunction

    logic [7:0] aes_b [4];
    logic [7:0] sha_b [4];

    task automatic do_reset();
        rst_n = 1'b0; aes_req = 1'b0; sha_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; aes_req = 1'b1; sha_req = 1'b1; bus_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, 15'h0);
        end
        rst_n = 1'b1; aes_req = 1'b0; sha_req = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL idle_no_req: got %h want %h", obs, 15'h0);
        end
    endtask

    task automatic test_aes_alone();
        aes_data_in = 32'hA1_123456; aes_req = 1'b1; bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            aes_req = 1'b0;
            checks++;
            if (obs !== ev(1'b1, 1'b0, 1'b1, 2'b01, 2'(i), aes_b[i])) begin
                errors++;
                $display("FAIL aes_alone byte%0d: got %h want %h", i, obs,
                         ev(1'b1, 1'b0, 1'b1, 2'b01, 2'(i), aes_b[i]));
            end
        end
        @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL aes_alone idle: got %h want %h", obs, 15'h0);
        end
    endtask

    task automatic test_sha_stalls();
        logic       rdy   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] e_cnt [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        logic [14:0] exp_v;
        sha_data_in = 32'h5B_ABCDEF; sha_req = 1'b1; bus_ready = 1'b0;
        @(negedge clk);
        sha_req = 1'b0;
        checks++;
        if (obs !== ev(1'b0, 1'b1, 1'b1, 2'b10, 2'd0, 8'h5B)) begin
            errors++;
            $display("FAIL sha_stall first: got %h want %h", obs,
                     ev(1'b0, 1'b1, 1'b1, 2'b10, 2'd0, 8'h5B));
        end
        @(negedge clk);
        checks++;
        if (obs !== ev(1'b0, 1'b1, 1'b1, 2'b10, 2'd0, 8'h5B)) begin
            errors++;
            $display("FAIL sha_stall hold0: got %h want %h", obs,
                     ev(1'b0, 1'b1, 1'b1, 2'b10, 2'd0, 8'h5B));
        end
        for (int c = 0; c < 7; c++) begin
            bus_ready = rdy[c];
            @(negedge clk);
            exp_v = (c == 6) ? 15'h0 :
                    ev(1'b0, 1'b1, 1'b1, 2'b10, e_cnt[c], sha_b[e_cnt[c]]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sha_stall step%0d: got %h want %h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_round_robin();
        int          phase, t;
        logic [14:0] exp_v;
        do_reset();
        aes_data_in = 32'hA1_123456; sha_data_in = 32'h5B_ABCDEF;
        aes_req = 1'b1; sha_req = 1'b1; bus_ready = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            phase = (k - 1) % 5;
            t     = (k - 1) / 5;
            if (phase == 4)
                exp_v = 15'h0;
            else if (t == 1)
                exp_v = ev(1'b0, 1'b1, 1'b1, 2'b10, 2'(phase), sha_b[phase]);
            else
                exp_v = ev(1'b1, 1'b0, 1'b1, 2'b01, 2'(phase), aes_b[phase]);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL round_robin cyc%0d: got %h want %h", k, obs, exp_v);
            end
            checks++;
            if ((aes_grant && sha_grant) !== 1'b0) begin
                errors++;
                $display("FAIL grant_onehot cyc%0d: got aes=%b sha=%b want not both",
                         k, aes_grant, sha_grant);
            end
        end
        aes_req = 1'b0; sha_req = 1'b0;
    endtask

    task automatic test_drop_midway();
        aes_data_in = 32'hA1_123456; aes_req = 1'b1; bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            aes_req     = 1'b0;
            aes_data_in = 32'hDEAD_BEEF;
            checks++;
            if (obs !== ev(1'b1, 1'b0, 1'b1, 2'b01, 2'(i), aes_b[i])) begin
                errors++;
                $display("FAIL drop_midway byte%0d: got %h want %h", i, obs,
                         ev(1'b1, 1'b0, 1'b1, 2'b01, 2'(i), aes_b[i]));
            end
        end
        @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL drop_midway idle: got %h want %h", obs, 15'h0);
        end
    endtask

    task automatic test_reset_midway();
        aes_data_in = 32'hA1_123456; aes_req = 1'b1; bus_ready = 1'b1;
        @(negedge clk);
        aes_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== ev(1'b1, 1'b0, 1'b1, 2'b01, 2'd2, 8'h34)) begin
            errors++;
            $display("FAIL reset_midway byte2: got %h want %h", obs,
                     ev(1'b1, 1'b0, 1'b1, 2'b01, 2'd2, 8'h34));
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL reset_midway abort: got %h want %h", obs, 15'h0);
        end
        rst_n = 1'b1; sha_data_in = 32'h5B_ABCDEF; sha_req = 1'b1;
        @(negedge clk);
        sha_req = 1'b0;
        checks++;
        if (obs !== ev(1'b0, 1'b1, 1'b1, 2'b10, 2'd0, 8'h5B)) begin
            errors++;
            $display("FAIL reset_midway restart: got %h want %h", obs,
                     ev(1'b0, 1'b1, 1'b1, 2'b10, 2'd0, 8'h5B));
        end
        repeat (4) @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL reset_midway done: got %h want %h", obs, 15'h0);
        end
    endtask

    initial begin
        aes_b = '{8'hA1, 8'h12, 8'h34, 8'h56};
        sha_b = '{8'h5B, 8'hAB, 8'hCD, 8'hEF};
        rst_n = 1'b0; aes_req = 1'b0; sha_req = 1'b0; bus_ready = 1'b0;
        aes_data_in = '0; sha_data_in = '0;
        test_reset();
        test_aes_alone();
        test_sha_stalls();
        test_round_robin();
        test_drop_midway();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Arbitrates between the SHA and AES cores for one shared 8-bit transaction bus.
- Each requester presents an {opcode, address} word of ADDRW+8 bits.
- The arbiter grants one requester, latches its word, and streams it MSB-byte-first with a valid/ready handshake.
- Debug outputs expose the current owner (mode) and the byte counter to the top level.

Parameters:
- ADDRW, 24, address width. Must be a multiple of 8 and at most 24, giving N = ADDRW/8 + 1 bytes per transaction (N ≤ 4, so the 2-bit counter suffices).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- sha_req  input  1  SHA requests the bus (level)
- aes_req  input  1  AES requests the bus (level)
- sha_data_in  input  ADDRW+8  SHA word; [ADDRW+7:ADDRW] opcode, [ADDRW-1:0] address
- aes_data_in  input  ADDRW+8  AES word, same layout
- bus_ready  input  1  downstream accepts data_out this cycle
- data_out  output  8  current byte; 8'h00 when valid_out=0
- valid_out  output  1  data_out holds a valid byte
- aes_grant  output  1  AES owns the bus
- sha_grant  output  1  SHA owns the bus
- curr_mode_top  output  2  owner: 2'b00 IDLE, 2'b01 AES, 2'b10 SHA (2'b11 never driven)
- counter_top  output  2  index of the byte currently presented; 0 in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - mode=IDLE, counter=0, grants=0, valid_out=0, data_out=0.
  - last_served=SHA, so AES wins the first contention.
- IDLE, edge with any request:
  - Pick the winner; register its grant=1 and mode.
  - Latch its full data_in word into a shift/hold register; counter=0.
  - Next cycle: valid_out=1, data_out = latched[ADDRW+7:ADDRW]. This is a 1-cycle latency from request to first byte.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting in IDLE: round-robin, the one not equal to last_served wins.
  - Requests are sampled only in IDLE.
  - At most one grant is high at any time.
- Transfer:
  - A byte is accepted on an edge with valid_out && bus_ready.
  - On acceptance with counter < N-1: counter++, and data_out moves to the next lower byte (byte k = latched[ADDRW+7-8k -: 8]).
  - valid_out=0 with bus_ready=0 is not a transfer; bus_ready=0 stalls and holds data_out/counter stable.
  - On acceptance of byte N-1: return to IDLE, drop grant and valid_out, counter=0, last_served = completed owner.
- Grant stays high from the cycle after selection until the cycle after the final byte is accepted.
- The bus is in IDLE for at least one cycle between transactions; back-to-back requests are re-arbitrated then.
- Request deasserted mid-transfer: ignored, the transfer completes. data_in changes after latching are ignored.
- Reset mid-transfer: abort immediately to the reset state, with no partial completion reporting.
- curr_mode_top and counter_top are direct copies of the internal registers.

Decomposition:
- Shared package bus_pkg:
  - mode encodings MODE_IDLE/MODE_AES/MODE_SHA (2-bit)
  - opcode byte field positions
  - NBYTES derivation from ADDRW
- No sub-module required. FSM, latch register and counter fit in one module of roughly 150 lines.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both reqs high -> all outputs 0, curr_mode_top=00.
- AES alone: aes_data_in=32'hA1_123456, bus_ready=1 -> aes_grant=1; bytes A1,12,34,56 on 4 consecutive cycles with counter_top 0..3 and curr_mode_top=01; then IDLE.
- SHA with stalls: sha_data_in=32'h5B_ABCDEF, bus_ready toggling 1,0,1,0 -> each byte held while bus_ready=0; order 5B,AB,CD,EF; sha_grant stays high throughout.
- Simultaneous requests from reset -> AES served first, then SHA. Keep both requesting -> grants alternate AES, SHA, AES; no cycle with both grants high.
- Request drop and data change mid-transfer: drop aes_req and change aes_data_in after byte 0 -> the original 4 bytes still complete.
- Reset mid-transfer: assert rst_n=0 during byte 2 -> next cycle grants=0, valid_out=0, counter_top=0; a fresh request afterwards restarts at byte 0.
